shared_mem_rr_arbiter: RTL and testbench
========================================

// Module: shared_mem_rr_arbiter
// PURPOSE
//  Parametrised N-core arbiter in front of the single-ported shared data memory of the manycore.
//  Replaces the fixed-priority, collision-blind selector with a round-robin arbiter.
//  Adds per-core grant and stall outputs, so losing cores freeze their PC.
//  Adds a bounded burst hold, so a winning core can finish back-to-back accesses.
// PARAMETERS
//  NUM_CORES  4   number of requesting cores (2..16)
//  ADDR_W     7   shared-memory word-address bits forwarded; upper 32-ADDR_W bits of mem_addr are driven 0
//  DATA_W     32  write-data width
//  MAX_BURST  2   max consecutive grants to one core while others wait (1 = strict alternation)
// PORTS
//  clk           in   1              system clock, all state on rising edge
//  reset         in   1              synchronous, active-high
//  req_addr      in   NUM_CORES*32   core i address at [32*i+:32]
//  req_wdata     in   NUM_CORES*DATA_W  core i store data at [DATA_W*i+:DATA_W]
//  req_rd        in   NUM_CORES      core i load strobe
//  req_wd        in   NUM_CORES      core i store strobe
//  req_sbit      in   NUM_CORES      core i address targets shared region
//  grant         out  NUM_CORES      one-hot; core i owns memory this cycle
//  stall         out  NUM_CORES      core i is requesting and not granted; it must hold its request
//  mem_addr      out  32             {0, owner addr[ADDR_W-1:0]}
//  mem_wdata     out  DATA_W         owner store data
//  mem_rd        out  1              owner load strobe
//  mem_wd        out  1              owner store strobe
//  shared_access out  1              |req_sbit; drives the shared/local read-data mux as before
// BEHAVIOUR
//  Requests
//   - req[i] = req_sbit[i] & (req_rd[i] | req_wd[i]).
//   - A core with sbit set but no rd/wd is not a request.
//  State
//   - Registers: FSM {IDLE, OWNED}, owner index, rr_ptr index, burst_cnt (clog2(MAX_BURST+1) bits).
//   - Reset values: IDLE, owner=0, rr_ptr=0, burst_cnt=0.
//  Zero-latency outputs
//   - Grant is combinational in the request cycle: a single-cycle core's access completes in the cycle it is granted.
//   - mem_* are muxed from the granted core.
//   - When grant==0: mem_addr=0, mem_wdata=0, mem_rd=0, mem_wd=0. There is no default core.
//   - stall = req & ~grant.
//  Winner selection (combinational)
//   - IDLE: first requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
//   - OWNED, req[owner]=1 and burst_cnt<MAX_BURST: owner keeps the grant.
//   - OWNED otherwise: first requester scanning owner+1 ... owner, modulo NUM_CORES. The owner wins again only if it is the sole requester.
//   - No requester: grant=0.
//  Transitions at the clock edge
//   - Winner exists, same as owner while OWNED: stay OWNED, burst_cnt <= burst_cnt+1.
//   - Winner exists, different core, or from IDLE: go OWNED, owner <= winner, burst_cnt <= 1.
//   - Sole-requester owner past MAX_BURST: burst_cnt <= 1. Unbounded hold is allowed when nobody waits.
//   - No winner: go IDLE, rr_ptr <= (owner+1) mod NUM_CORES.
//  Fairness
//   - Any continuously requesting core is granted within (NUM_CORES-1)*MAX_BURST cycles.
//  Reset
//   - While reset=1, outputs are forced: grant=0, mem_rd=mem_wd=0, mem_addr=mem_wdata=0. stall=req, so cores hold.
//   - Reset mid-burst discards owner and burst_cnt. Next arbitration starts from core 0.
//  Arithmetic
//   - Indices are clog2(NUM_CORES) bits.
//   - Wrap uses an explicit compare with NUM_CORES-1, so non-power-of-2 NUM_CORES is valid.
//  Simultaneous events
//   - Request drop and new request in the same cycle: handled by the same winner logic, no idle bubble.
// TESTING
//  1 Reset: reset=1 with req=4'b1111 -> grant=0, stall=4'b1111, mem_rd=mem_wd=0. First cycle after reset -> grant=4'b0001.
//  2 Rotation: MAX_BURST=1, req=4'b1111 held 8 cycles -> grant sequence 0001,0010,0100,1000,0001,...; stall never on the granted core.
//  3 Burst: MAX_BURST=2, core1 and core3 requesting constantly -> grant 0010,0010,1000,1000,0010,...
//  4 Sole requester: only core2 requests for 5 cycles -> grant=0100 every cycle, burst_cnt wraps to 1, no stall.
//  5 Mux/width: core3 wd=1, addr=32'hFFFF_FF85, wdata=32'hDEAD_BEEF, granted -> mem_addr=32'h0000_0005, mem_wdata=32'hDEAD_BEEF, mem_wd=1.
//  6 Idle/pointer: core0 served then all requests drop -> grant=0, mem_*=0. Next req=4'b0011 -> core1 granted first; reset mid-burst -> core0 granted first.

Source files
------------

// File: rtl/shared_mem_rr_arbiter.sv
// shared_mem_rr_arbiter
//   Round-robin arbiter in front of the single-ported shared data memory.
//   Grant is combinational in the request cycle. A winning core may hold the
//   memory for up to MAX_BURST back-to-back cycles while others wait, and
//   indefinitely while nobody else requests.
//
// Ports
//   clk            system clock, all state on rising edge
//   reset          synchronous, active-high
//   req_addr       core i address at [32*i +: 32]
//   req_wdata      core i store data at [DATA_W*i +: DATA_W]
//   req_rd         per-core load strobe
//   req_wd         per-core store strobe
//   req_sbit       per-core "address targets the shared region"
//   grant          one-hot owner of the memory this cycle
//   stall          core requests but is not granted; it must hold its request
//   mem_addr       zero-extended low ADDR_W bits of the owner's address
//   mem_wdata      owner store data
//   mem_rd         owner load strobe
//   mem_wd         owner store strobe
//   shared_access  |req_sbit, selects shared/local read data
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no owner; next scan starts at rr_ptr
// S_OWNED | owner held memory last cycle; burst_cnt counts its grants

module shared_mem_rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES*32-1:0]     req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    input  logic [NUM_CORES-1:0]        req_rd,
    input  logic [NUM_CORES-1:0]        req_wd,
    input  logic [NUM_CORES-1:0]        req_sbit,
    output logic [NUM_CORES-1:0]        grant,
    output logic [NUM_CORES-1:0]        stall,
    output logic [31:0]                 mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_rd,
    output logic                        mem_wd,
    output logic                        shared_access
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CORES - 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        S_IDLE,
        S_OWNED
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     burst_cnt;

    logic [NUM_CORES-1:0] req;
    logic                 hold;
    logic                 win_valid;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;

    // Explicit compare instead of modulo so non-power-of-2 core counts wrap correctly.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    assign req = req_sbit & (req_rd | req_wd);

    // Winner search. When the owner's burst is exhausted the scan starts
    // just past it, so it only wins again if nobody else is asking.
    always_comb begin
        hold      = (state == S_OWNED) && req[owner] && (burst_cnt < BURST_MAX);
        win_valid = 1'b0;
        win_idx   = owner;
        cand      = (state == S_OWNED) ? next_idx(owner) : rr_ptr;
        if (hold) begin
            win_valid = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (!win_valid && req[cand]) begin
                    win_valid = 1'b1;
                    win_idx   = cand;
                end
                cand = next_idx(cand);
            end
        end
    end

    assign grant         = (win_valid && !reset) ? (NUM_CORES'(1) << win_idx) : '0;
    assign stall         = req & ~grant;
    assign shared_access = |req_sbit;

    // Grant is one-hot or zero, so an OR-style mux leaves all-zero when nobody owns.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wd    = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                mem_addr  = 32'(req_addr[32*i +: ADDR_W]);
                mem_wdata = req_wdata[DATA_W*i +: DATA_W];
                mem_rd    = req_rd[i];
                mem_wd    = req_wd[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (win_valid) begin
            if (state == S_OWNED && win_idx == owner) begin
                // Not holding here means a sole requester past its burst: restart count.
                burst_cnt <= hold ? burst_cnt + 1'b1 : CNT_ONE;
            end else begin
                state     <= S_OWNED;
                owner     <= win_idx;
                burst_cnt <= CNT_ONE;
            end
        end else begin
            state  <= S_IDLE;
            rr_ptr <= next_idx(owner);
        end
    end

endmodule

// File: tb/tb_shared_mem_rr_arbiter.sv
module tb_shared_mem_rr_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [31:0]   a_addr [N];
    logic [31:0]   a_wdata[N];
    logic [N-1:0]  rd, wd, sbit;
    logic [N*32-1:0] req_addr, req_wdata;

    assign req_addr  = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
    assign req_wdata = {a_wdata[3], a_wdata[2], a_wdata[1], a_wdata[0]};

    logic [N-1:0] grant_a, stall_a, grant_b, stall_b;
    logic [31:0]  mem_addr_a, mem_wdata_a, mem_addr_b, mem_wdata_b;
    logic         mem_rd_a, mem_wd_a, sh_a, mem_rd_b, mem_wd_b, sh_b;

    shared_mem_rr_arbiter #(.NUM_CORES(4), .ADDR_W(7), .DATA_W(32), .MAX_BURST(2)) dut_a (
        .clk(clk), .reset(reset), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(rd), .req_wd(wd), .req_sbit(sbit),
        .grant(grant_a), .stall(stall_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rd(mem_rd_a), .mem_wd(mem_wd_a), .shared_access(sh_a));

    shared_mem_rr_arbiter #(.NUM_CORES(4), .ADDR_W(7), .DATA_W(32), .MAX_BURST(1)) dut_b (
        .clk(clk), .reset(reset), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(rd), .req_wd(wd), .req_sbit(sbit),
        .grant(grant_b), .stall(stall_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rd(mem_rd_b), .mem_wd(mem_wd_b), .shared_access(sh_b));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: index 0 tracks dut_a (burst 2), index 1 tracks dut_b (burst 1).
    int m_owned[2] = '{0, 0};
    int m_owner[2] = '{0, 0};
    int m_ptr[2]   = '{0, 0};
    int m_cnt[2]   = '{0, 0};
    int mb[2]      = '{2, 1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] mreq();
        return sbit & (rd | wd);
    endfunction

    function automatic int mwin(input int d);
        logic [N-1:0] r;
        r = mreq();
        if (reset) return -1;
        if (m_owned[d] != 0) begin
            if (r[m_owner[d]] && m_cnt[d] < mb[d]) return m_owner[d];
            for (int k = 1; k <= N; k++)
                if (r[(m_owner[d] + k) % N]) return (m_owner[d] + k) % N;
            return -1;
        end
        for (int k = 0; k < N; k++)
            if (r[(m_ptr[d] + k) % N]) return (m_ptr[d] + k) % N;
        return -1;
    endfunction

    task automatic mupdate();
        for (int d = 0; d < 2; d++) begin
            int w;
            w = mwin(d);
            if (reset) begin
                m_owned[d] = 0; m_owner[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
            end else if (w < 0) begin
                m_owned[d] = 0;
                m_ptr[d]   = (m_owner[d] + 1) % N;
            end else if (m_owned[d] != 0 && w == m_owner[d]) begin
                m_cnt[d] = (m_cnt[d] < mb[d]) ? m_cnt[d] + 1 : 1;
            end else begin
                m_owned[d] = 1; m_owner[d] = w; m_cnt[d] = 1;
            end
        end
    endtask

    task automatic check_dut(input int d);
        int w;
        logic [N-1:0] eg, es;
        logic [31:0]  ea, ed;
        logic         er, ew;
        w  = mwin(d);
        eg = (w < 0) ? '0 : (N'(1) << w);
        es = mreq() & ~eg;
        ea = (w < 0) ? 32'h0 : (a_addr[w] & 32'h0000_007F);
        ed = (w < 0) ? 32'h0 : a_wdata[w];
        er = (w < 0) ? 1'b0 : rd[w];
        ew = (w < 0) ? 1'b0 : wd[w];
        if (d == 0) begin
            chk("a_grant", 64'(grant_a), 64'(eg));
            chk("a_stall", 64'(stall_a), 64'(es));
            chk("a_mem_addr", 64'(mem_addr_a), 64'(ea));
            chk("a_mem_wdata", 64'(mem_wdata_a), 64'(ed));
            chk("a_mem_rd", 64'(mem_rd_a), 64'(er));
            chk("a_mem_wd", 64'(mem_wd_a), 64'(ew));
            chk("a_shared", 64'(sh_a), 64'(|sbit));
        end else begin
            chk("b_grant", 64'(grant_b), 64'(eg));
            chk("b_stall", 64'(stall_b), 64'(es));
            chk("b_mem_addr", 64'(mem_addr_b), 64'(ea));
            chk("b_mem_wdata", 64'(mem_wdata_b), 64'(ed));
            chk("b_mem_rd", 64'(mem_rd_b), 64'(er));
            chk("b_mem_wd", 64'(mem_wd_b), 64'(ew));
            chk("b_shared", 64'(sh_b), 64'(|sbit));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        mupdate();
        #1;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] rd, wd, sbit;
        logic [N-1:0] g, st;
    } vec_t;

    vec_t tv[20];

    initial begin
        // Hand-derived sequence for the burst-2 instance; state carries across rows.
        tv[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111}; // reset holds
        tv[1]  = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0001, 4'b1110}; // core0 first
        tv[2]  = '{1'b0, 4'b1010, 4'b0000, 4'b1010, 4'b0010, 4'b1000}; // burst 1/3
        tv[3]  = '{1'b0, 4'b1010, 4'b0000, 4'b1010, 4'b0010, 4'b1000};
        tv[4]  = '{1'b0, 4'b1010, 4'b0000, 4'b1010, 4'b1000, 4'b0010};
        tv[5]  = '{1'b0, 4'b1010, 4'b0000, 4'b1010, 4'b1000, 4'b0010};
        tv[6]  = '{1'b0, 4'b1010, 4'b0000, 4'b1010, 4'b0010, 4'b1000};
        tv[7]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000}; // sole core2
        tv[8]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
        tv[9]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
        tv[10] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
        tv[11] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
        tv[12] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000}; // core0 served
        tv[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000}; // idle
        tv[14] = '{1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0010, 4'b0001}; // ptr=1
        tv[15] = '{1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0010, 4'b0001};
        tv[16] = '{1'b1, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0011}; // reset mid-burst
        tv[17] = '{1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0001, 4'b0010}; // back to core0
        tv[18] = '{1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000}; // sbit alone
        tv[19] = '{1'b0, 4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0000}; // rd w/o sbit

        for (int i = 0; i < N; i++) begin
            a_addr[i]  = 32'h1234_5600 + 32'(i * 17);
            a_wdata[i] = 32'hC0DE_0000 + 32'(i);
        end
        reset = 1'b1; rd = '0; wd = '0; sbit = '0;
        advance();

        for (int i = 0; i < 20; i++) begin
            reset = tv[i].rst; rd = tv[i].rd; wd = tv[i].wd; sbit = tv[i].sbit;
            @(negedge clk);
            chk($sformatf("tv%0d_grant", i), 64'(grant_a), 64'(tv[i].g));
            chk($sformatf("tv%0d_stall", i), 64'(stall_a), 64'(tv[i].st));
            check_dut(0);
            check_dut(1);
            advance();
        end

        // Strict alternation on the burst-1 instance.
        reset = 1'b1; rd = 4'b1111; wd = '0; sbit = 4'b1111;
        @(negedge clk);
        chk("rot_reset_grant", 64'(grant_b), 64'(0));
        advance();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("rot%0d_grant", k), 64'(grant_b), 64'(4'b0001 << (k % 4)));
            chk($sformatf("rot%0d_stall_on_grant", k), 64'(stall_b & grant_b), 64'(0));
            check_dut(0);
            check_dut(1);
            advance();
        end

        // Address truncation and data mux from core3.
        reset = 1'b1; rd = '0; wd = '0; sbit = '0;
        advance();
        reset = 1'b0; wd = 4'b1000; sbit = 4'b1000;
        a_addr[3] = 32'hFFFF_FF85; a_wdata[3] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mux_grant", 64'(grant_a), 64'(4'b1000));
        chk("mux_addr", 64'(mem_addr_a), 64'(32'h0000_0005));
        chk("mux_wdata", 64'(mem_wdata_a), 64'(32'hDEAD_BEEF));
        chk("mux_wd", 64'(mem_wd_a), 64'(1));
        chk("mux_rd", 64'(mem_rd_a), 64'(0));
        advance();

        // Random traffic against the model; inputs are often held to build bursts.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 0) begin
                rd   = N'($urandom);
                wd   = N'($urandom);
                sbit = N'($urandom | $urandom);
            end
            for (int i = 0; i < N; i++) begin
                a_addr[i]  = $urandom;
                a_wdata[i] = $urandom;
            end
            @(negedge clk);
            check_dut(0);
            check_dut(1);
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
